llr_loader: RTL and testbench

LLR_LOADER -- requirements
Module: llr_loader

---
 rtl/llr_loader.sv | 187 ++++++++++++++++++
 tb/tb_llr_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/llr_loader.sv
// Double-buffered LLR frame loader: serial signed samples fill a frame buffer that is handed to the decoder bus l.
// Optional build macro LLR_SAT_EN clips every accepted sample to [-LLR_MAX, +LLR_MAX] before storage.
module llr_loader #(
    parameter int R       = 24,
    parameter int D       = 24,
    parameter int data_w  = 12,
    parameter int LLR_MAX = 63,
    localparam int N      = R * D,
    localparam int CW     = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [data_w-1:0]     in_llr,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [N*data_w-1:0]   l,
    output logic                  l_valid,
    input  logic                  l_ack,
    output logic                  frame_err,
    output logic [CW-1:0]         fill_cnt
);

    localparam int LW = N * data_w;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LW-1:0]       r_fill;
    logic [LW-1:0]       r_l;
    logic                r_l_valid;
    logic                r_frame_err;
    logic [CW-1:0]       r_fill_cnt;

    logic [data_w-1:0]   w_llr;
    logic [LW-1:0]       w_fill_shift;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_at_end;
    logic                w_frame_ok;
    logic                w_frame_bad;
    logic                w_slot_free;
    logic                w_load_direct;
    logic                w_load_wait;

`ifdef LLR_SAT_EN
    function automatic logic [data_w-1:0] sat_llr(input logic [data_w-1:0] x);
        logic signed [data_w-1:0] s;
        logic signed [data_w-1:0] hi;
        logic signed [data_w-1:0] lo;
        s  = $signed(x);
        hi = data_w'(LLR_MAX);
        lo = -hi;
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

    assign w_llr = sat_llr(in_llr);
`else
    assign w_llr = in_llr;
`endif

    // Samples shift in at the LSB end so that sample 0 ends up in the MSB slot after N accepts.
    assign w_fill_shift  = {r_fill[LW-data_w-1:0], w_llr};

    assign w_accept      = in_valid && w_in_ready;
    assign w_at_end      = (r_fill_cnt == CW'(N - 1));
    assign w_frame_ok    = w_accept && in_last && w_at_end;
    assign w_frame_bad   = w_accept && (in_last != w_at_end);
    assign w_slot_free   = !r_l_valid || l_ack;
    assign w_load_direct = w_frame_ok && w_slot_free;
    assign w_load_wait   = (r_state == S_WAIT) && l_ack;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if (w_frame_ok && !w_slot_free) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_FILL;
                end
            end
            S_WAIT: begin
                if (l_ack) begin
                    w_state_nxt = S_FILL;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    // FSM output decode
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            S_FILL:  w_in_ready = 1'b1;
            S_WAIT:  w_in_ready = 1'b0;
            default: w_in_ready = 1'b0;
        endcase
    end

    // Fill buffer; stale content after a dropped frame is fully overwritten by the next N accepts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fill <= '0;
        end else if (w_accept) begin
            r_fill <= w_fill_shift;
        end else begin
            r_fill <= r_fill;
        end
    end

    // Fill count: cleared on a hand-off or a dropped frame, otherwise counts accepts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fill_cnt <= CW'(0);
        end else if (w_load_wait) begin
            r_fill_cnt <= CW'(0);
        end else if (w_accept) begin
            if (w_frame_bad || w_load_direct) begin
                r_fill_cnt <= CW'(0);
            end else begin
                r_fill_cnt <= r_fill_cnt + CW'(1);
            end
        end else begin
            r_fill_cnt <= r_fill_cnt;
        end
    end

    // Output slot: l only changes on a hand-off, so it stays stable while the decoder reads it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_l       <= '0;
            r_l_valid <= 1'b0;
        end else if (w_load_direct) begin
            r_l       <= w_fill_shift;
            r_l_valid <= 1'b1;
        end else if (w_load_wait) begin
            r_l       <= r_fill;
            r_l_valid <= 1'b1;
        end else if (l_ack) begin
            r_l       <= r_l;
            r_l_valid <= 1'b0;
        end else begin
            r_l       <= r_l;
            r_l_valid <= r_l_valid;
        end
    end

    // Malformed-frame pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
        end
    end

    assign in_ready  = w_in_ready;
    assign l         = r_l;
    assign l_valid   = r_l_valid;
    assign frame_err = r_frame_err;
    assign fill_cnt  = r_fill_cnt;

endmodule

// File: tb/tb_llr_loader.sv
// Directed, scoreboard-based bench for llr_loader; expected frames are packed from the stimulus table.
module tb_llr_loader;

    localparam int R  = 24;
    localparam int D  = 24;
    localparam int W  = 12;
    localparam int N  = R * D;
    localparam int CW = $clog2(N + 1);
    localparam int LW = N * W;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_llr;
    logic           in_last;
    logic           in_ready;
    logic [LW-1:0]  l;
    logic           l_valid;
    logic           l_ack;
    logic           frame_err;
    logic [CW-1:0]  fill_cnt;

    int             n_vec;
    int             n_err;
    int             n_stall;
    int             smp [N];
    logic [LW-1:0]  sbq [$];
    logic [LW-1:0]  frame_a;
    logic [LW-1:0]  frame_b;
    logic [W-1:0]   e0;
    logic [W-1:0]   e1;
    logic [W-1:0]   e2;

    llr_loader #(.R(R), .D(D), .data_w(W), .LLR_MAX(63)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_llr    (in_llr),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .l         (l),
        .l_valid   (l_valid),
        .l_ack     (l_ack),
        .frame_err (frame_err),
        .fill_cnt  (fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sat_m(input int v);
`ifdef LLR_SAT_EN
        if (v > 63) return 63;
        else if (v < -63) return -63;
        else return v;
`else
        return v;
`endif
    endfunction

    function automatic logic [LW-1:0] pack_frame();
        logic [LW-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++) f[(N-1-k)*W +: W] = W'(sat_m(smp[k]));
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [LW-1:0] exp);
        int first;
        n_vec++;
        assert (l === exp) else begin
            n_err++;
            first = -1;
            for (int k = 0; k < N; k++)
                if (first < 0 && l[(N-1-k)*W +: W] !== exp[(N-1-k)*W +: W]) first = k;
            $error("FAIL %s: first bad sample %0d observed %0h expected %0h", tag, first,
                   l[(N-1-first)*W +: W], exp[(N-1-first)*W +: W]);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [LW-1:0] exp;
        chk({tag, "_sb_depth"}, 64'(sbq.size() > 0), 64'd1);
        if (sbq.size() > 0) begin
            exp = sbq.pop_front();
            chk_frame(tag, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] v, input logic last, input logic ack);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_llr   = v;
        in_last  = last;
        l_ack    = ack;
        while (in_ready !== 1'b1 && t < 4000) begin
            n_stall++;
            @(negedge clk);
            t++;
        end
        if (t >= 4000) chk("ready_timeout", 64'(t), 64'd0);
        @(posedge clk);
    endtask

    task automatic send_frame(input int n, input int last_idx, input bit ack_last);
        for (int k = 0; k < n; k++)
            drive(W'(smp[k]), k == last_idx, ack_last && (k == last_idx));
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_stall = 0;
        rst = 1'b0; in_valid = 1'b0; in_llr = '0; in_last = 1'b0; l_ack = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_fill_cnt", 64'(fill_cnt), 64'd0);
        chk("rst_l_valid", 64'(l_valid), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk_frame("rst_l_zero", '0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Frame A, slot free, no ack
        for (int k = 0; k < N; k++) smp[k] = k % 100;
        frame_a = pack_frame();
        sbq.push_back(frame_a);
        send_frame(N, N-1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("a_l_valid", 64'(l_valid), 64'd1);
        pop_check("a_frame");
        chk("a_msb_slot", 64'(l[LW-1 -: W]), 64'd0);
        chk("a_lsb_slot", 64'(l[W-1:0]), 64'd75);
        chk("a_fill_cnt", 64'(fill_cnt), 64'd0);
        chk("a_in_ready", 64'(in_ready), 64'd1);
        chk("a_no_stall", 64'(n_stall), 64'd0);

        // Frame B while A unacked -> WAIT
        for (int k = 0; k < N; k++) smp[k] = (k * 37 + 5) % 4096;
        frame_b = pack_frame();
        sbq.push_back(frame_b);
        send_frame(N, N-1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b_wait_in_ready", 64'(in_ready), 64'd0);
        chk("b_wait_fill_cnt", 64'(fill_cnt), 64'(N));
        chk("b_wait_l_valid", 64'(l_valid), 64'd1);
        chk_frame("b_wait_l_stable", frame_a);
        @(negedge clk);
        chk_frame("b_wait_l_stable2", frame_a);
        l_ack = 1'b1;
        @(negedge clk);
        l_ack = 1'b0;
        chk("b_l_valid", 64'(l_valid), 64'd1);
        pop_check("b_frame");
        chk("b_fill_cnt", 64'(fill_cnt), 64'd0);
        chk("b_in_ready", 64'(in_ready), 64'd1);

        // Early in_last on sample 10
        for (int k = 0; k < 11; k++) smp[k] = k + 1;
        send_frame(11, 10, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("early_frame_err", 64'(frame_err), 64'd1);
        chk("early_fill_cnt", 64'(fill_cnt), 64'd0);
        chk("early_l_valid", 64'(l_valid), 64'd1);
        chk_frame("early_l_kept", frame_b);
        @(negedge clk);
        chk("early_err_pulse", 64'(frame_err), 64'd0);

        // Missing in_last on sample N-1
        for (int k = 0; k < N; k++) smp[k] = 500 + (k % 9);
        send_frame(N, -1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("nolast_frame_err", 64'(frame_err), 64'd1);
        chk("nolast_fill_cnt", 64'(fill_cnt), 64'd0);
        chk_frame("nolast_l_kept", frame_b);

        // Release the slot, then ack with nothing valid
        l_ack = 1'b1;
        @(negedge clk);
        l_ack = 1'b0;
        chk("ack_clears_valid", 64'(l_valid), 64'd0);
        l_ack = 1'b1;
        @(negedge clk);
        l_ack = 1'b0;
        chk("ack_idle_valid", 64'(l_valid), 64'd0);
        chk("ack_idle_in_ready", 64'(in_ready), 64'd1);

        // Reset after 300 samples, then a full frame
        for (int k = 0; k < N; k++) smp[k] = 200 + (k % 100);
        send_frame(300, -1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_fill_cnt", 64'(fill_cnt), 64'd0);
        chk("midrst_l_valid", 64'(l_valid), 64'd0);
        rst = 1'b1;
        for (int k = 0; k < N; k++) smp[k] = -(k % 50);
        sbq.push_back(pack_frame());
        send_frame(N, N-1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("c_l_valid", 64'(l_valid), 64'd1);
        pop_check("c_frame");

        // Saturation frame, loaded while acking the previous frame on the same edge
        for (int k = 0; k < N; k++) smp[k] = k % 7;
        smp[0] = 100; smp[1] = -100; smp[2] = 40;
        sbq.push_back(pack_frame());
        send_frame(N, N-1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; l_ack = 1'b0;
`ifdef LLR_SAT_EN
        e0 = W'(63); e1 = W'(-63);
`else
        e0 = W'(100); e1 = W'(-100);
`endif
        e2 = W'(40);
        chk("sat_l_valid", 64'(l_valid), 64'd1);
        chk("sat_in_ready", 64'(in_ready), 64'd1);
        chk("sat_fill_cnt", 64'(fill_cnt), 64'd0);
        pop_check("sat_frame");
        chk("sat_slot0", 64'(l[LW-1 -: W]), 64'(e0));
        chk("sat_slot1", 64'(l[LW-W-1 -: W]), 64'(e1));
        chk("sat_slot2", 64'(l[LW-2*W-1 -: W]), 64'(e2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
